// File: rtl/simple_add_example_pkg.sv
// +----------------------------------------------------------------------------+
// | simple_add_example_pkg                                                     |
// | Shared FSM encoding, tdest width and clog2 helper for the adder front end. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package simple_add_example_pkg;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_XFER = 1'b1;

    localparam int LP_TDEST_WIDTH = 16;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/simple_add_example_axis_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | simple_add_example_axis_arbiter_if                                         |
// | Flattened multi-source AXI4-Stream input plus the single arbitrated output.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface simple_add_example_axis_arbiter_if #(
    parameter int C_NUM_SRC          = 4,
    parameter int C_AXIS_TDATA_WIDTH = 512
);
    import simple_add_example_pkg::*;

    localparam int c_KEEP_W = C_AXIS_TDATA_WIDTH / 8;

    logic [C_NUM_SRC-1:0]                    s_axis_tvalid;
    logic [C_NUM_SRC-1:0]                    s_axis_tready;
    logic [C_NUM_SRC*C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata;
    logic [C_NUM_SRC*c_KEEP_W-1:0]           s_axis_tkeep;
    logic [C_NUM_SRC-1:0]                    s_axis_tlast;

    logic                                    m_axis_tvalid;
    logic                                    m_axis_tready;
    logic [C_AXIS_TDATA_WIDTH-1:0]           m_axis_tdata;
    logic [c_KEEP_W-1:0]                     m_axis_tkeep;
    logic                                    m_axis_tlast;
    logic [LP_TDEST_WIDTH-1:0]               m_axis_tdest;

    // The arbiter sinks the source streams and sources the adder stream.
    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest,
        output m_axis_tready
    );

endinterface

`default_nettype wire

// File: rtl/simple_add_example_axis_reg_slice.sv
// +----------------------------------------------------------------------------+
// | simple_add_example_axis_reg_slice                                          |
// | Two-entry skid buffer: registered outputs and a registered input ready.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module simple_add_example_axis_reg_slice #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_valid,
    output logic                  o_ready,
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  wire logic             i_ready,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_occupied
);

    logic             r_main_valid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_in_fire;
    logic             w_main_free;

    assign w_in_fire   = i_valid & r_in_ready;
    assign w_main_free = ~r_main_valid | i_ready;

    // Input ready tracks "skid will be empty next cycle", so an accepted beat
    // always has a home even if the consumer stalls on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_main_data <= i_data;
                end
            end
            r_in_ready <= 1'b1;
        end else if (w_in_fire) begin
            r_skid_data  <= i_data;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end else begin
            r_in_ready <= ~r_skid_valid;
        end
    end

    assign o_ready    = r_in_ready;
    assign o_valid    = r_main_valid;
    assign o_data     = r_main_data;
    assign o_occupied = r_main_valid | r_skid_valid;

endmodule

`default_nettype wire

// File: rtl/simple_add_example_axis_arbiter.sv
// +----------------------------------------------------------------------------+
// | simple_add_example_axis_arbiter                                            |
// | Packet-level round-robin arbiter feeding the adder; grant index on tdest.  |
// | Optional per-source packet counters: SIMPLE_ADD_EXAMPLE_ARB_PKT_COUNT_EN.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module simple_add_example_axis_arbiter
    import simple_add_example_pkg::*;
#(
    parameter int C_NUM_SRC          = 4,
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_SRC_IDX_WIDTH    = 2
) (
    input  wire logic                     s_axis_aclk,
    input  wire logic                     s_axis_areset,
    input  wire logic                     ctrl_enable,
    simple_add_example_axis_arbiter_if.slave axis,
    output logic                          busy,
    output logic [C_NUM_SRC*32-1:0]       pkt_count
);

    localparam int c_KEEP_W    = C_AXIS_TDATA_WIDTH / 8;
    localparam int c_PAYLOAD_W = C_AXIS_TDATA_WIDTH + c_KEEP_W + 1 + LP_TDEST_WIDTH;
    localparam int c_IDX_W_REQ = (clog2(C_NUM_SRC) < 1) ? 1 : clog2(C_NUM_SRC);
    localparam logic [C_SRC_IDX_WIDTH-1:0] c_RR_INIT = C_SRC_IDX_WIDTH'(C_NUM_SRC - 1);

    if (C_SRC_IDX_WIDTH != c_IDX_W_REQ || C_NUM_SRC < 2 || C_NUM_SRC > 16) begin : g_bad_params
        $error("simple_add_example_axis_arbiter: C_NUM_SRC must be 2..16 and C_SRC_IDX_WIDTH = clog2(C_NUM_SRC)");
    end

    logic [0:0]                    r_state;
    logic [C_SRC_IDX_WIDTH-1:0]    r_grant;
    logic [C_SRC_IDX_WIDTH-1:0]    r_rr_ptr;
    logic [C_SRC_IDX_WIDTH-1:0]    w_pick;
    logic                          w_found;
    logic                          w_xfer;
    logic                          w_sel_valid;
    logic                          w_sel_last;
    logic [C_AXIS_TDATA_WIDTH-1:0] w_sel_data;
    logic [c_KEEP_W-1:0]           w_sel_keep;
    logic                          w_slice_in_valid;
    logic                          w_slice_in_ready;
    logic                          w_slice_occupied;
    logic                          w_beat;
    logic [c_PAYLOAD_W-1:0]        w_in_payload;
    logic [c_PAYLOAD_W-1:0]        w_out_payload;

    // Scan starts one past the last winner so every source gets a turn.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= C_NUM_SRC; k++) begin
            idx = (int'(r_rr_ptr) + k) % C_NUM_SRC;
            if (!w_found && axis.s_axis_tvalid[idx]) begin
                w_found = 1'b1;
                w_pick  = C_SRC_IDX_WIDTH'(idx);
            end
        end
    end

    assign w_xfer           = (r_state == c_XFER);
    assign w_sel_valid      = axis.s_axis_tvalid[r_grant];
    assign w_sel_last       = axis.s_axis_tlast[r_grant];
    assign w_sel_data       = axis.s_axis_tdata[r_grant*C_AXIS_TDATA_WIDTH +: C_AXIS_TDATA_WIDTH];
    assign w_sel_keep       = axis.s_axis_tkeep[r_grant*c_KEEP_W +: c_KEEP_W];
    assign w_slice_in_valid = w_xfer & w_sel_valid;
    assign w_beat           = w_slice_in_valid & w_slice_in_ready;
    assign w_in_payload     = {w_sel_data, w_sel_keep, w_sel_last, LP_TDEST_WIDTH'(r_grant)};

    always_comb begin
        axis.s_axis_tready = '0;
        if (w_xfer && w_slice_in_ready) begin
            axis.s_axis_tready[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            r_state  <= c_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= c_RR_INIT;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (ctrl_enable && w_found) begin
                        r_grant <= w_pick;
                        r_state <= c_XFER;
                    end
                end
                c_XFER: begin
                    if (w_beat && w_sel_last) begin
                        r_rr_ptr <= r_grant;
                        r_state  <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    simple_add_example_axis_reg_slice #(
        .WIDTH (c_PAYLOAD_W)
    ) u_out_slice (
        .clk        (s_axis_aclk),
        .rst        (s_axis_areset),
        .i_valid    (w_slice_in_valid),
        .o_ready    (w_slice_in_ready),
        .i_data     (w_in_payload),
        .o_valid    (axis.m_axis_tvalid),
        .i_ready    (axis.m_axis_tready),
        .o_data     (w_out_payload),
        .o_occupied (w_slice_occupied)
    );

    assign {axis.m_axis_tdata, axis.m_axis_tkeep, axis.m_axis_tlast, axis.m_axis_tdest} = w_out_payload;
    assign busy = w_xfer | w_slice_occupied;

`ifdef SIMPLE_ADD_EXAMPLE_ARB_PKT_COUNT_EN
    for (genvar gi = 0; gi < C_NUM_SRC; gi++) begin : g_pkt_cnt
        logic [31:0] r_cnt;
        always_ff @(posedge s_axis_aclk) begin
            if (s_axis_areset) begin
                r_cnt <= '0;
            end else if (w_beat && w_sel_last && (r_grant == C_SRC_IDX_WIDTH'(gi))) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
        assign pkt_count[gi*32 +: 32] = r_cnt;
    end
`else
    assign pkt_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_simple_add_example_axis_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_simple_add_example_axis_arbiter                                         |
// | Scoreboard bench: per-source packet queues in, expected-beat queue out.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_simple_add_example_axis_arbiter;
    import simple_add_example_pkg::*;

    localparam int c_NS = 4;
    localparam int c_DW = 32;
    localparam int c_KW = c_DW / 8;
    localparam int c_IW = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic                    s_axis_aclk;
    logic                    s_axis_areset;
    logic                    ctrl_enable;
    logic                    busy;
    logic [c_NS*32-1:0]      pkt_count;

    beat_t                   src_q [c_NS][$];
    logic [52:0]             exp_q [$];
    logic [c_NS-1:0]         src_hold;
    int                      ready_mode;
    int                      n_checks;
    int                      n_errors;

    simple_add_example_axis_arbiter_if #(
        .C_NUM_SRC          (c_NS),
        .C_AXIS_TDATA_WIDTH (c_DW)
    ) axis_bus ();

    simple_add_example_axis_arbiter #(
        .C_NUM_SRC          (c_NS),
        .C_AXIS_TDATA_WIDTH (c_DW),
        .C_SRC_IDX_WIDTH    (c_IW)
    ) dut (
        .s_axis_aclk   (s_axis_aclk),
        .s_axis_areset (s_axis_areset),
        .ctrl_enable   (ctrl_enable),
        .axis          (axis_bus),
        .busy          (busy),
        .pkt_count     (pkt_count)
    );

    initial s_axis_aclk = 1'b0;
    always #5 s_axis_aclk = ~s_axis_aclk;

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beat_word(input int src, input int tag, input int beat);
        return {8'(src), 8'(tag), 16'(beat + 1)};
    endfunction

    function automatic logic [3:0] beat_keep(input int src, input int beat);
        return 4'((beat + src) % 15 + 1);
    endfunction

    task automatic send_pkt(input int src, input int tag, input int n);
        for (int b = 0; b < n; b++) begin
            src_q[src].push_back('{data: beat_word(src, tag, b), keep: beat_keep(src, b), last: (b == n - 1)});
        end
    endtask

    // Expected beats are queued in the order the round-robin should grant them.
    task automatic expect_pkt(input int src, input int tag, input int n);
        for (int b = 0; b < n; b++) begin
            exp_q.push_back({(b == n - 1), 16'(src), beat_keep(src, b), beat_word(src, tag, b)});
        end
    endtask

    function automatic int src_pending();
        int n;
        n = 0;
        for (int i = 0; i < c_NS; i++) n += src_q[i].size();
        return n;
    endfunction

    // Commit handshakes that the coming rising edge will take, then drive the
    // next stimulus on the falling edge.
    task automatic tick();
        logic [52:0] got;
        beat_t       head;
        if (!s_axis_areset) begin
            for (int i = 0; i < c_NS; i++) begin
                if (axis_bus.s_axis_tvalid[i] && axis_bus.s_axis_tready[i]) begin
                    void'(src_q[i].pop_front());
                end
            end
            if (axis_bus.m_axis_tvalid && axis_bus.m_axis_tready) begin
                got = {axis_bus.m_axis_tlast, axis_bus.m_axis_tdest, axis_bus.m_axis_tkeep, axis_bus.m_axis_tdata};
                if (exp_q.size() == 0) check_value("unexpected_beat", got, 53'd0);
                else                   check_value("beat", got, exp_q.pop_front());
            end
        end
        @(posedge s_axis_aclk);
        @(negedge s_axis_aclk);
        for (int i = 0; i < c_NS; i++) begin
            if (src_q[i].size() > 0 && !src_hold[i]) begin
                head = src_q[i][0];
                axis_bus.s_axis_tvalid[i]               = 1'b1;
                axis_bus.s_axis_tdata[i*c_DW +: c_DW]   = head.data;
                axis_bus.s_axis_tkeep[i*c_KW +: c_KW]   = head.keep;
                axis_bus.s_axis_tlast[i]                = head.last;
            end else begin
                axis_bus.s_axis_tvalid[i]               = 1'b0;
                axis_bus.s_axis_tdata[i*c_DW +: c_DW]   = '0;
                axis_bus.s_axis_tkeep[i*c_KW +: c_KW]   = '0;
                axis_bus.s_axis_tlast[i]                = 1'b0;
            end
        end
        case (ready_mode)
            0:       axis_bus.m_axis_tready = 1'b1;
            1:       axis_bus.m_axis_tready = ~axis_bus.m_axis_tready;
            default: axis_bus.m_axis_tready = 1'($urandom_range(0, 1));
        endcase
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int left;
        left = 300;
        while ((exp_q.size() > 0 || src_pending() > 0) && left > 0) begin
            tick();
            left--;
        end
        check_value({tag, "_drain"}, 128'(exp_q.size() + src_pending()), 128'd0);
        tick();
        tick();
    endtask

    task automatic do_reset();
        s_axis_areset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < c_NS; i++) src_q[i].delete();
        tick();
        tick();
        s_axis_areset = 1'b0;
    endtask

    initial begin
        int left;
        n_checks   = 0;
        n_errors   = 0;
        ready_mode = 0;
        src_hold   = '0;
        s_axis_areset = 1'b1;
        ctrl_enable   = 1'b1;
        axis_bus.s_axis_tvalid = '0;
        axis_bus.s_axis_tdata  = '0;
        axis_bus.s_axis_tkeep  = '0;
        axis_bus.s_axis_tlast  = '0;
        axis_bus.m_axis_tready = 1'b1;
        tick();
        tick();
        check_value("rst_m_tvalid", axis_bus.m_axis_tvalid, 0);
        check_value("rst_s_tready", axis_bus.s_axis_tready, 0);
        check_value("rst_busy", busy, 0);
        check_value("rst_pkt_count", pkt_count, 0);
        s_axis_areset = 1'b0;

        // Single 3-beat packet from source 0: two-cycle latency to first output.
        send_pkt(0, 0, 3);
        expect_pkt(0, 0, 3);
        tick();
        tick();
        check_value("s1_tvalid_bubble", axis_bus.m_axis_tvalid, 0);
        check_value("s1_tready_grant0", axis_bus.s_axis_tready, 4'b0001);
        tick();
        check_value("s1_first_out", {axis_bus.m_axis_tvalid, axis_bus.m_axis_tdata}, {1'b1, 32'h1});
        wait_drain("s1");

        // All sources busy with 2-beat packets: grants 0,1,2,3,0,1.
        do_reset();
        send_pkt(0, 1, 2); send_pkt(0, 2, 2);
        send_pkt(1, 1, 2); send_pkt(1, 2, 2);
        send_pkt(2, 1, 2);
        send_pkt(3, 1, 2);
        expect_pkt(0, 1, 2); expect_pkt(1, 1, 2); expect_pkt(2, 1, 2);
        expect_pkt(3, 1, 2); expect_pkt(0, 2, 2); expect_pkt(1, 2, 2);
        tick(); tick(); tick(); tick();
        check_value("s2_busy", busy, 1);
        wait_drain("s2");

        // Source 2 wins (pointer at 1), toggling ready, with a mid-packet stall.
        ready_mode = 1;
        send_pkt(2, 3, 8);
        send_pkt(1, 3, 2);
        expect_pkt(2, 3, 8);
        expect_pkt(1, 3, 2);
        for (int i = 0; i < 6; i++) tick();
        src_hold[2] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_value("s3_hold_src1_off", axis_bus.s_axis_tready[1], 0);
        check_value("s3_hold_busy", busy, 1);
        src_hold[2] = 1'b0;
        wait_drain("s3");
        ready_mode = 0;

        // Disable mid-packet: the packet finishes, src3 waits for re-enable.
        do_reset();
        send_pkt(1, 4, 4);
        send_pkt(3, 4, 2);
        expect_pkt(1, 4, 4);
        expect_pkt(3, 4, 2);
        left = 20;
        while (src_q[1].size() > 3 && left > 0) begin tick(); left--; end
        ctrl_enable = 1'b0;
        left = 40;
        while (exp_q.size() > 2 && left > 0) begin tick(); left--; end
        check_value("s4_pkt_complete", exp_q.size(), 2);
        for (int i = 0; i < 5; i++) tick();
        check_value("s4_no_grant", src_q[3].size(), 2);
        check_value("s4_idle_busy", busy, 0);
        check_value("s4_idle_tready", axis_bus.s_axis_tready, 0);
        ctrl_enable = 1'b1;
        tick();
        check_value("s4_src3_granted", axis_bus.s_axis_tready, 4'b1000);
        wait_drain("s4");

        // Reset mid-packet flushes the slice; next grant goes to source 0.
        do_reset();
        send_pkt(2, 5, 6);
        expect_pkt(2, 5, 6);
        left = 20;
        while (exp_q.size() > 4 && left > 0) begin tick(); left--; end
        check_value("s5_partial", exp_q.size(), 4);
        s_axis_areset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < c_NS; i++) src_q[i].delete();
        tick();
        check_value("s5_rst_tvalid", axis_bus.m_axis_tvalid, 0);
        check_value("s5_rst_tready", axis_bus.s_axis_tready, 0);
        s_axis_areset = 1'b0;
        send_pkt(3, 6, 1);
        send_pkt(0, 6, 1);
        expect_pkt(0, 6, 1);
        expect_pkt(3, 6, 1);
        wait_drain("s5");

        // Packet counters: five from source 1, two from source 3.
        do_reset();
        for (int k = 0; k < 5; k++) send_pkt(1, 7 + k, 1);
        send_pkt(3, 12, 1);
        send_pkt(3, 13, 1);
        expect_pkt(1, 7, 1);  expect_pkt(3, 12, 1);
        expect_pkt(1, 8, 1);  expect_pkt(3, 13, 1);
        expect_pkt(1, 9, 1);  expect_pkt(1, 10, 1); expect_pkt(1, 11, 1);
        wait_drain("s6");
`ifdef SIMPLE_ADD_EXAMPLE_ARB_PKT_COUNT_EN
        check_value("s6_pkt_count", pkt_count, {32'd2, 32'd0, 32'd5, 32'd0});
`else
        check_value("s6_pkt_count", pkt_count, 128'd0);
`endif

        // Random backpressure; pointer at 1 so source 2 precedes source 0.
        ready_mode = 2;
        send_pkt(0, 20, 3);
        send_pkt(2, 20, 1);
        expect_pkt(2, 20, 1);
        expect_pkt(0, 20, 3);
        wait_drain("s7");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
